// File: rtl/biriscv_wb_arbiter_pkg.sv
// biriscv writeback definitions shared by the arbiter and its buffer.
// Register index/data widths and the {rd, value} entry layout.
package biriscv_wb_arbiter_pkg;

  localparam int RW = 5;
  localparam int XW = 32;

  typedef logic [RW-1:0] rd_t;
  typedef logic [XW-1:0] xlen_t;

  typedef struct packed {
    rd_t   rd;
    xlen_t value;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BUF,
    SRC_WB0,
    SRC_WB1
  } wb_src_e;

endpackage

// File: rtl/biriscv_wb_arbiter_fifo.sv
// Writeback holding buffer: two in-order pushes and one pop per cycle.
// Exposes per-slot valid/rd so the arbiter can build the pending mask.
module biriscv_wb_fifo
  import biriscv_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push0_i,
  input  wb_entry_t             push0_data_i,
  input  logic                  push1_i,
  input  wb_entry_t             push1_data_i,
  input  logic                  pop_i,
  output wb_entry_t             head_o,
  output logic [CW-1:0]         count_o,
  output logic [DEPTH-1:0]      ent_vld_o,
  output rd_t [DEPTH-1:0]       ent_rd_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wptr1;
  logic [CW-1:0] cnt_q, cnt_d;

  // push1 lands behind push0 when both push in the same cycle
  assign wptr1 = wptr_q + PW'(push0_i);

  always_comb begin
    rptr_d = rptr_q + PW'(pop_i);
    wptr_d = wptr_q + PW'(push0_i) + PW'(push1_i);
    cnt_d  = cnt_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push0_i) mem_q[wptr_q] <= push0_data_i;
    if (push1_i) mem_q[wptr1]  <= push1_data_i;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] off;
    assign off          = PW'(g) - rptr_q;
    assign ent_vld_o[g] = {1'b0, off} < cnt_q;
    assign ent_rd_o[g]  = mem_q[g].rd;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/biriscv_wb_arbiter.sv
// Dual-pipe writeback arbiter onto one register-file write port.
// Writes commit in program order; overflow goes to a small buffer.
module biriscv_wb_arbiter
  import biriscv_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb0_valid_i,
  input  logic [RW-1:0] wb0_rd_i,
  input  logic [XW-1:0] wb0_value_i,
  input  logic          wb1_valid_i,
  input  logic [RW-1:0] wb1_rd_i,
  input  logic [XW-1:0] wb1_value_i,
  output logic          wb0_ready_o,
  output logic          wb1_ready_o,
  output logic [RW-1:0] rd0_o,
  output logic [XW-1:0] rd0_value_o,
  output logic [31:0]   pending_o,
  output logic          idle_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW + 1;

  logic [CW-1:0]      cnt;
  logic               buf_nz;
  logic [AW-1:0]      avail;
  wb_entry_t          head;
  logic [DEPTH-1:0]   ent_vld;
  rd_t [DEPTH-1:0]    ent_rd;
  logic               acc0, acc1;
  logic               sel_buf, sel0, sel1;
  logic               push0, push1;
  wb_src_e            src;

  assign buf_nz = |cnt;
  assign idle_o = ~buf_nz;

  // slots usable this edge, counting the one freed by the head pop
  assign avail = AW'(DEPTH) - {1'b0, cnt} + AW'(buf_nz);

  assign wb0_ready_o = ~buf_nz | (avail != '0);
  assign wb1_ready_o = buf_nz ? (avail >= AW'(2)) : (avail != '0);

  assign acc0 = wb0_valid_i & wb0_ready_o & (wb0_rd_i != '0);
  assign acc1 = wb1_valid_i & wb1_ready_o & (wb1_rd_i != '0);

  assign sel_buf = buf_nz;
  assign sel0    = ~buf_nz & acc0;
  assign sel1    = ~buf_nz & ~acc0 & acc1;

  assign push0 = acc0 & buf_nz;
  assign push1 = acc1 & (buf_nz | acc0);

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      sel_buf: src = SRC_BUF;
      sel0:    src = SRC_WB0;
      sel1:    src = SRC_WB1;
      default: src = SRC_NONE;
    endcase
  end

  always_comb begin
    rd0_o       = '0;
    rd0_value_o = '0;
    unique case (src)
      SRC_BUF: begin
        rd0_o       = head.rd;
        rd0_value_o = head.value;
      end
      SRC_WB0: begin
        rd0_o       = wb0_rd_i;
        rd0_value_o = wb0_value_i;
      end
      SRC_WB1: begin
        rd0_o       = wb1_rd_i;
        rd0_value_o = wb1_value_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending_o[ent_rd[i]] = 1'b1;
    end
    pending_o[0] = 1'b0;
  end

  biriscv_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push0_i     (push0),
    .push0_data_i('{rd: wb0_rd_i, value: wb0_value_i}),
    .push1_i     (push1),
    .push1_data_i('{rd: wb1_rd_i, value: wb1_value_i}),
    .pop_i       (buf_nz),
    .head_o      (head),
    .count_o     (cnt),
    .ent_vld_o   (ent_vld),
    .ent_rd_o    (ent_rd)
  );

endmodule

// File: tb/tb_biriscv_wb_arbiter.sv
// Scoreboard bench for biriscv_wb_arbiter: model predicts ready/pending,
// monitor checks every register-file write against the expected order.
module tb_biriscv_wb_arbiter;
  import biriscv_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          wb0_valid_i, wb1_valid_i;
  logic [RW-1:0] wb0_rd_i, wb1_rd_i;
  logic [XW-1:0] wb0_value_i, wb1_value_i;
  logic          wb0_ready_o, wb1_ready_o;
  logic [RW-1:0] rd0_o;
  logic [XW-1:0] rd0_value_o;
  logic [31:0]   pending_o;
  logic          idle_o;

  int checks = 0;
  int errors = 0;

  wb_entry_t exp_q[$];
  wb_entry_t mbuf[$];
  logic [31:0] ref_img [32];
  logic [31:0] dut_img [32];

  always #5 clk = ~clk;

  biriscv_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wb0_valid_i(wb0_valid_i),
    .wb0_rd_i   (wb0_rd_i),
    .wb0_value_i(wb0_value_i),
    .wb1_valid_i(wb1_valid_i),
    .wb1_rd_i   (wb1_rd_i),
    .wb1_value_i(wb1_value_i),
    .wb0_ready_o(wb0_ready_o),
    .wb1_ready_o(wb1_ready_o),
    .rd0_o      (rd0_o),
    .rd0_value_o(rd0_value_o),
    .pending_o  (pending_o),
    .idle_o     (idle_o)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    wb_entry_t e;
    if (rd0_o != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d val=%h expected none",
                 rd0_o, rd0_value_o);
      end else begin
        e = exp_q.pop_front();
        if (e.rd !== rd0_o || e.value !== rd0_value_o) begin
          errors++;
          $display("FAIL write_order: got rd=%0d val=%h expected rd=%0d val=%h",
                   rd0_o, rd0_value_o, e.rd, e.value);
        end
        ref_img[e.rd] = e.value;
        dut_img[rd0_o] = rd0_value_o;
      end
    end else begin
      chk("idle_value", rd0_value_o, 32'h0);
    end
  end

  task automatic step(input logic v0, input logic [4:0] r0,
                      input logic [31:0] d0, input logic v1,
                      input logic [4:0] r1, input logic [31:0] d1);
    int c, a;
    bit e0, e1;
    logic [31:0] pm;
    wb_entry_t acc[$];
    c  = mbuf.size();
    a  = DEPTH - c + (c > 0 ? 1 : 0);
    e0 = (c == 0) || (a >= 1);
    e1 = (a >= (c == 0 ? 1 : 2));
    pm = '0;
    foreach (mbuf[i]) pm[mbuf[i].rd] = 1'b1;
    pm[0] = 1'b0;
    chk("wb0_ready", 32'(wb0_ready_o), 32'(e0));
    chk("wb1_ready", 32'(wb1_ready_o), 32'(e1));
    chk("idle", 32'(idle_o), 32'(c == 0));
    chk("pending", pending_o, pm);
    wb0_valid_i = v0; wb0_rd_i = r0; wb0_value_i = d0;
    wb1_valid_i = v1; wb1_rd_i = r1; wb1_value_i = d1;
    if (v0 && e0 && r0 != 0) acc.push_back('{rd: r0, value: d0});
    if (v1 && e1 && r1 != 0) acc.push_back('{rd: r1, value: d1});
    foreach (acc[i]) exp_q.push_back(acc[i]);
    if (c > 0) begin
      void'(mbuf.pop_front());
      foreach (acc[i]) mbuf.push_back(acc[i]);
    end else begin
      for (int i = 1; i < acc.size(); i++) mbuf.push_back(acc[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && mbuf.size() != 0; i++) idle_step();
    idle_step();
    chk("drain", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    foreach (ref_img[i]) begin
      ref_img[i] = '0;
      dut_img[i] = '0;
    end
    rst_i = 1'b0;
    wb0_valid_i = 1'b0; wb0_rd_i = '0; wb0_value_i = '0;
    wb1_valid_i = 1'b0; wb1_rd_i = '0; wb1_value_i = '0;
    #2;
    chk("rst_idle", 32'(idle_o), 32'h1);
    chk("rst_pending", pending_o, 32'h0);
    chk("rst_rd0", 32'(rd0_o), 32'h0);
    chk("rst_ready0", 32'(wb0_ready_o), 32'h1);
    chk("rst_ready1", 32'(wb1_ready_o), 32'h1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;

    // direct single write
    step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
    idle_step();
    // same rd from both pipes
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
    idle_step();
    idle_step();
    // rd 0 discarded, wb1 written directly
    step(1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h22);
    idle_step();
    // saturate the buffer
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(2 * i + 1), 32'h100 + 32'(i),
           1'b1, 5'(2 * i + 2), 32'h200 + 32'(i));
    drain();

    // reset with three buffered entries
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(20 + i), 32'h300 + 32'(i),
           1'b1, 5'(24 + i), 32'h400 + 32'(i));
    chk("pre_reset_idle", 32'(idle_o), 32'h0);
    wb0_valid_i = 1'b0;
    wb1_valid_i = 1'b0;
    #1;
    rst_i = 1'b0;
    #1;
    chk("async_rst_idle", 32'(idle_o), 32'h1);
    chk("async_rst_pending", pending_o, 32'h0);
    mbuf.delete();
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) idle_step();

    // random traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
    drain();

    for (int r = 1; r < 32; r++) chk($sformatf("img_x%0d", r), dut_img[r], ref_img[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
